// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the multi-cycle add/subtract sequencer.
package alu_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count n slices; never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/cla_slice16.sv
// Combinational 16-bit carry-lookahead adder: 4-bit groups under a second lookahead level.
module cla_slice16
  import alu_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a16,
  input  logic [SLICE_W-1:0] b16,
  input  logic               cin,
  output logic [SLICE_W-1:0] s16,
  output logic               cout
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [3:0]  w_gc;

  assign w_g = a16 & b16;
  assign w_p = a16 ^ b16;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_grp
      localparam int B = gi * 4;
      assign w_gg[gi] = w_g[B+3]
                      | (w_p[B+3] & w_g[B+2])
                      | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                      | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
      assign w_gp[gi] = &w_p[B+3:B];
      assign w_c[B]   = w_gc[gi];
      assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[gi]);
      assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_gc[gi]);
      assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                      | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[gi]);
    end
  endgenerate

  // Second level: group carries computed directly from group generate/propagate.
  assign w_gc[0] = cin;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & cin);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & cin);
  assign cout    = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & cin);

  assign s16 = w_p ^ w_c;

endmodule

// File: rtl/alu_addsub_seq.sv
// Add/subtract sequencer: one 16-bit CLA slice reused per cycle, LSB slice first,
// with the inter-slice carry held in a register.
module alu_addsub_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = idx_width(NSLICE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [SLICE_W-1:0] w_a_sl [NSLICE];
  logic [SLICE_W-1:0] w_b_sl [NSLICE];
  logic [SLICE_W-1:0] w_a16;
  logic [SLICE_W-1:0] w_b16;
  logic [SLICE_W-1:0] w_s16;
  logic               w_sc;
  logic [WIDTH-1:0]   w_sum_new;
  logic               w_accept;
  logic               w_last;

  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_sl
      assign w_a_sl[gi] = r_a[gi*SLICE +: SLICE];
      assign w_b_sl[gi] = r_b[gi*SLICE +: SLICE];
      assign w_sum_new[gi*SLICE +: SLICE] = (r_idx == IW'(gi)) ? w_s16 : r_sum[gi*SLICE +: SLICE];
    end
  endgenerate

  assign w_a16 = w_a_sl[r_idx];
  assign w_b16 = w_b_sl[r_idx];

  cla_slice16 u_slice (
    .a16  (w_a16),
    .b16  (w_b16),
    .cin  (r_carry),
    .s16  (w_s16),
    .cout (w_sc)
  );

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_state == RUN) && (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1; the +1 enters as the first slice's carry-in.
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum   <= w_sum_new;
      r_carry <= w_sc;
      r_idx   <= w_last ? '0 : r_idx + IW'(1);
      if (w_last) begin
        r_cout <= w_sc;
        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum_new[WIDTH-1] != r_a[WIDTH-1]);
        r_zero <= (w_sum_new == '0);
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_addsub_seq.sv
// Directed bench: every scenario runs on a 32-bit and a 64-bit instance in turn.
module tb_alu_addsub_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic in_valid = 1'b0;
  logic sub = 1'b0;
  logic out_ready = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;

  logic        ir32, ov32, c32, o32, z32;
  logic        ir64, ov64, c64, o64, z64;
  logic [31:0] s32;
  logic [63:0] s64;

  logic        o_in_ready, o_out_valid, o_cout, o_ovf, o_zero;
  logic [63:0] o_sum;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_addsub_seq #(.WIDTH(32), .SLICE(16)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(ir32),
    .a(a[31:0]), .b(b[31:0]), .sub(sub), .out_valid(ov32), .out_ready(out_ready & ~sel),
    .sum(s32), .cout(c32), .ovf(o32), .zero(z32)
  );

  alu_addsub_seq #(.WIDTH(64), .SLICE(16)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(ir64),
    .a(a), .b(b), .sub(sub), .out_valid(ov64), .out_ready(out_ready & sel),
    .sum(s64), .cout(c64), .ovf(o64), .zero(z64)
  );

  assign o_in_ready  = sel ? ir64 : ir32;
  assign o_out_valid = sel ? ov64 : ov32;
  assign o_sum       = sel ? s64 : {32'd0, s32};
  assign o_cout      = sel ? c64 : c32;
  assign o_ovf       = sel ? o64 : o32;
  assign o_zero      = sel ? z64 : z32;

  // Drives one operation; returns the result and the accept-to-out_valid latency (99 on timeout).
  task automatic do_op(input logic [63:0] av, input logic [63:0] bv, input logic s, input bit rel,
                       output logic [63:0] rs, output logic rc, output logic ro, output logic rz,
                       output int lat);
    @(negedge clk);
    a = av; b = bv; sub = s; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; a = '1; b = '1; sub = ~s;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (o_out_valid) begin lat = i; break; end
    end
    rs = o_sum; rc = o_cout; ro = o_ovf; rz = o_zero;
    a = '0; b = '0; sub = 1'b0;
    if (rel) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({o_in_ready, o_out_valid, o_sum, o_cout, o_ovf, o_zero} !== {1'b1, 1'b0, 64'd0, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_state w%0d: in_ready=%b out_valid=%b sum=%h c/o/z=%b%b%b, required 1 0 0 000",
               sel ? 64 : 32, o_in_ready, o_out_valid, o_sum, o_cout, o_ovf, o_zero);
    end
  endtask

  task automatic test_cross_carry();
    logic [63:0] rs, es; logic rc, ro, rz; int lat;
    es = sel ? 64'h0001_0000_0000_0000 : 64'h0000_0000_0001_0000;
    do_op(sel ? 64'h0000_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b1, rs, rc, ro, rz, lat);
    n_cmp++;
    if (lat !== (sel ? 4 : 2)) begin
      n_bad++; $display("FAIL cross_latency w%0d: got %0d required %0d", sel ? 64 : 32, lat, sel ? 4 : 2);
    end
    n_cmp++;
    if ({rs, rc, ro, rz} !== {es, 3'b000}) begin
      n_bad++; $display("FAIL cross_carry w%0d: got sum=%h c/o/z=%b%b%b required sum=%h c/o/z=000",
                        sel ? 64 : 32, rs, rc, ro, rz, es);
    end
    $display("cross_carry w%0d: sum=%h lat=%0d", sel ? 64 : 32, rs, lat);
  endtask

  task automatic test_equal_sub();
    logic [63:0] rs; logic rc, ro, rz; int lat;
    do_op(64'd5, 64'd5, 1'b1, 1'b1, rs, rc, ro, rz, lat);
    n_cmp++;
    if ({rs, rc, ro, rz} !== {64'd0, 3'b101} || lat !== (sel ? 4 : 2)) begin
      n_bad++; $display("FAIL equal_sub w%0d: got sum=%h c/o/z=%b%b%b lat=%0d required sum=0 c/o/z=101",
                        sel ? 64 : 32, rs, rc, ro, rz, lat);
    end
    $display("equal_sub w%0d: sum=%h zero=%b", sel ? 64 : 32, rs, rz);
  endtask

  // Overflow and wrap vectors: {a, b, sub, sum, cout, ovf, zero}, built for the current width.
  task automatic test_ovf_wrap();
    logic [63:0] msb, ones, rs; logic rc, ro, rz; int lat;
    logic [63:0] va [4], vb [4], vs [4];
    logic        vsub [4];
    logic [2:0]  vf [4];
    msb  = sel ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    ones = sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    va[0] = msb - 64'd1; vb[0] = 64'd1; vsub[0] = 1'b0; vs[0] = msb;         vf[0] = 3'b010;
    va[1] = msb;         vb[1] = 64'd1; vsub[1] = 1'b1; vs[1] = msb - 64'd1; vf[1] = 3'b110;
    va[2] = ones;        vb[2] = 64'd1; vsub[2] = 1'b0; vs[2] = 64'd0;       vf[2] = 3'b101;
    va[3] = 64'd0;       vb[3] = 64'd1; vsub[3] = 1'b1; vs[3] = ones;        vf[3] = 3'b000;
    for (int k = 0; k < 4; k++) begin
      do_op(va[k], vb[k], vsub[k], 1'b1, rs, rc, ro, rz, lat);
      n_cmp++;
      if ({rs, rc, ro, rz} !== {vs[k], vf[k]}) begin
        n_bad++; $display("FAIL ovf_wrap[%0d] w%0d: got sum=%h c/o/z=%b%b%b required sum=%h c/o/z=%b",
                          k, sel ? 64 : 32, rs, rc, ro, rz, vs[k], vf[k]);
      end
      $display("ovf_wrap[%0d] w%0d: sum=%h c/o/z=%b%b%b", k, sel ? 64 : 32, rs, rc, ro, rz);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] rs; logic rc, ro, rz; int lat;
    do_op(64'd3, 64'd4, 1'b0, 1'b0, rs, rc, ro, rz, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 64'd100 + 64'(k); b = 64'd1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n_cmp++;
      if ({o_out_valid, o_in_ready, o_sum, o_cout, o_ovf, o_zero} !== {2'b10, 64'd7, 3'b000}) begin
        n_bad++; $display("FAIL hold[%0d] w%0d: got valid=%b ready=%b sum=%h c/o/z=%b%b%b required 1 0 7 000",
                          k, sel ? 64 : 32, o_out_valid, o_in_ready, o_sum, o_cout, o_ovf, o_zero);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_cmp++;
    if ({o_out_valid, o_in_ready} !== 2'b01) begin
      n_bad++; $display("FAIL release w%0d: got valid=%b ready=%b required 0 1", sel ? 64 : 32, o_out_valid, o_in_ready);
    end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if ({o_out_valid, o_in_ready} !== 2'b01) begin
      n_bad++; $display("FAIL ignored_pulses w%0d: got valid=%b ready=%b required 0 1", sel ? 64 : 32, o_out_valid, o_in_ready);
    end
    $display("backpressure w%0d: held sum=%h for 5 cycles", sel ? 64 : 32, rs);
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] rs, es; logic rc, ro, rz; int lat;
    @(negedge clk);
    a = 64'h0000_1111_0000_1111; b = 64'h0000_2222_0000_2222; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_in_ready, o_out_valid, o_sum, o_cout, o_ovf, o_zero} !== {2'b10, 64'd0, 3'b000}) begin
      n_bad++; $display("FAIL mid_run_reset w%0d: got ready=%b valid=%b sum=%h c/o/z=%b%b%b required 1 0 0 000",
                        sel ? 64 : 32, o_in_ready, o_out_valid, o_sum, o_cout, o_ovf, o_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    es = sel ? 64'h2345_6789_ABCD_F001 : 64'h0000_0000_2345_6789;
    do_op(sel ? 64'h1234_5678_9ABC_DEF0 : 64'h0000_0000_1234_5678,
          sel ? 64'h1111_1111_1111_1111 : 64'h0000_0000_1111_1111, 1'b0, 1'b1, rs, rc, ro, rz, lat);
    n_cmp++;
    if ({rs, rc, ro, rz} !== {es, 3'b000} || lat !== (sel ? 4 : 2)) begin
      n_bad++; $display("FAIL after_reset w%0d: got sum=%h c/o/z=%b%b%b lat=%0d required sum=%h c/o/z=000",
                        sel ? 64 : 32, rs, rc, ro, rz, lat, es);
    end
    $display("reset_mid_run w%0d: new op sum=%h", sel ? 64 : 32, rs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 2; w++) begin
      sel = w[0];
      rst_n = 1'b0;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_cross_carry();
      test_equal_sub();
      test_ovf_wrap();
      test_backpressure();
      test_reset_mid_run();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
